inv_key_scheduler: RTL
======================

Name: inv_key_scheduler

Overview:
Decryption-side companion to the forward AES-128 key expansion. It accepts the final (round 10) key and regenerates round keys 10, 9, …, 0 in descending order, one per accepted handshake, using the inverse key-schedule recurrence. It sits between the key store and the inverse-cipher datapath, which consumes keys through a valid/ready stream. This removes the need for an 11-entry key RAM on the decrypt path.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; only 10 (AES-128) is supported, and the key-index width is fixed at 4 bits.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous, active-low reset
start  input  1  single-cycle request; sampled only in IDLE
last_key  input  128  round-10 key, sampled on the cycle start is accepted
abort  input  1  synchronous clear to IDLE; has priority over all other inputs except n_rst
key_ready  input  1  consumer accepts round_key this cycle
key_valid  output  1  round_key/key_index hold a valid key
round_key  output  128  current round key; word 0 = bits [127:96]
key_index  output  4  round number of round_key (10 down to 0)
busy  output  1  high in EMIT and DONE
done  output  1  one-cycle pulse after key 0 is accepted

Behaviour:
- Reset: state IDLE, work register 0, key_index 0, key_valid 0, busy 0, done 0, round_key 0.
- States: IDLE, EMIT, DONE.
- IDLE: on start, latch work <= last_key and idx <= 10, then go to EMIT. start in any other state is ignored.
- EMIT: key_valid=1, round_key=work, key_index=idx.
  - On key_valid && key_ready with idx != 0: work <= inv(work, rcon[idx]), idx <= idx-1, stay in EMIT.
  - On key_valid && key_ready with idx == 0: go to DONE.
  - With key_ready low: round_key and key_index hold stable. No change is allowed while valid && !ready.
- DONE: done=1 and key_valid=0 for exactly one cycle, then IDLE. busy=1 in DONE.
- Latency: start accepted at edge N gives key_valid high from cycle N+1. With key_ready held high, 11 consecutive keys are emitted and done pulses in the cycle after key 0.
- Inverse step: input words w0..w3 (w0 = MSW); output words p0..p3.
  - p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0.
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon[idx], 24'h0}.
  - RotWord rotates bytes left by one: {b1, b2, b3, b0}.
- rcon[idx] for idx=1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. The table is indexed by the round being left (idx), not the round being produced.
- All XOR is 32-bit with no carry. The S-box is combinational and is applied only to p3, which comes from XORs only, so the critical path is one XOR, then the S-box, then two XORs.
- abort in any state: next state IDLE, key_valid 0, done not pulsed, work retained but don't-care.
- Reset asserted mid-operation: immediate asynchronous return to reset values. No key is emitted after n_rst deasserts until a new start.
- start and abort in the same IDLE cycle: abort wins and start is dropped.

Decomposition:
- Package aes_pkg holds:
  - state enum inv_ks_state_t {IDLE, EMIT, DONE}
  - AES_ROUNDS = 10
  - the rcon lookup function, shared with the forward generator
- Sub-module aes_inv_g_word (combinational): inputs p3[31:0] and rcon[7:0]; output SubWord(RotWord(p3)) ^ {rcon, 24'h0}. It contains the forward S-box ROM.
- All other logic (state register, work register, idx counter, handshake) lives in inv_key_scheduler.

Test Plan:
1. FIPS-197 A.1 round trip.
   - Stimulus: start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1.
   - Response:
     - idx 10 → d014f9a8c9ee2589e13f0cc8b6630ca6
     - idx 9 → ac7766f319fadc2128d12941575c006e
     - idx 0 → 2b7e151628aed2a6abf7158809cf4f3c
     - done pulses in the cycle after idx 0 is accepted.
2. Backpressure.
   - Stimulus: same key; key_ready toggles 1,0,0,1,…
   - Response: round_key and key_index are unchanged on every cycle with ready=0. Exactly 11 transfers occur, in order 10..0.
3. Latency and throughput.
   - Stimulus: start at cycle 0, ready constant 1.
   - Response: key_valid high in cycles 1–11, done=1 in cycle 12, busy falls at cycle 13.
4. start while busy.
   - Stimulus: assert start with a different last_key during EMIT at idx 5.
   - Response: the stream continues unchanged through idx 0, and the new key is ignored.
5. abort at idx 4.
   - Response: key_valid drops the next cycle, no done pulse, state IDLE. A fresh start then reproduces scenario 1 exactly.
6. Async reset mid-stream.
   - Stimulus: pulse n_rst low at idx 7.
   - Response: all outputs are 0 immediately, and nothing is emitted until a new start.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types, constants and round-constant lookup
//
// Contents:
//   inv_ks_state_t : inverse key scheduler state encoding (IDLE, EMIT, DONE)
//   AES_ROUNDS     : round count for AES-128
//   rcon()         : round constant for a given round number (1..10), 0 otherwise
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } inv_ks_state_t;

  localparam int AES_ROUNDS = 10;

  // Indexed by round number; the inverse scheduler passes the round it is
  // leaving, the forward generator the round it is producing.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_g_word.sv
// rtl/aes_inv_g_word.sv - key-schedule g function: SubWord(RotWord(p3)) ^ {rcon, 24'h0}
//
// Ports:
//   p3   in  32  most recently recovered last word of the previous round key
//   rcon in   8  round constant of the round being left
//   g    out 32  word to XOR into w0 to recover p0
module aes_inv_g_word (
  input  logic [31:0] p3,
  input  logic [7:0]  rcon,
  output logic [31:0] g
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [31:0] rot;
  logic [31:0] sub;

  always_comb begin
    // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
    rot = {p3[23:0], p3[31:24]};
    sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    g   = sub ^ {rcon, 24'h0};
  end

endmodule

// File: rtl/inv_key_scheduler.sv
// rtl/inv_key_scheduler.sv - regenerates AES-128 round keys 10..0 from the round-10 key
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   start, last_key     begin a sequence from the round-10 key (IDLE only)
//   abort               synchronous return to IDLE, overrides start/handshake
//   key_valid/key_ready round-key stream handshake
//   round_key           current round key, word 0 in bits [127:96]
//   key_index           round number of round_key (10 down to 0)
//   busy                high in EMIT and DONE
//   done                one-cycle pulse after key 0 is accepted
module inv_key_scheduler
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_ROUNDS
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         abort,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   key_index,
  output logic         busy,
  output logic         done
);

  inv_ks_state_t state_q, state_d;
  logic [127:0]  work_q, work_d;
  logic [3:0]    idx_q, idx_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] g;

  // p3 comes from XORs only, so the S-box sits between one XOR level and two.
  assign w0 = work_q[127:96];
  assign w1 = work_q[95:64];
  assign w2 = work_q[63:32];
  assign w3 = work_q[31:0];
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ g;

  aes_inv_g_word u_g_word (
    .p3   (p3),
    .rcon (rcon(idx_q)),
    .g    (g)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    idx_d     = idx_q;
    key_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = last_key;
          idx_d   = 4'(NUM_ROUNDS);
          state_d = EMIT;
        end
      end
      EMIT: begin
        key_valid = 1'b1;
        busy      = 1'b1;
        if (key_ready) begin
          if (idx_q != 4'd0) begin
            work_d = {p0, p1, p2, p3};
            idx_d  = idx_q - 4'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort freezes the key state so a start in the same cycle loads nothing.
    if (abort) begin
      state_d = IDLE;
      work_d  = work_q;
      idx_d   = idx_q;
    end
  end

  assign round_key = work_q;
  assign key_index = idx_q;

endmodule
